// File: rtl/dtw_core_ref_reader.sv
// Streams the stored reference sequence out of the DTW reference memory as a
// valid/ready sample stream. Reads are issued against a 4-entry skid buffer
// with credit-based flow control, so the one-cycle memory latency never stalls
// the stream under continuous ready.

module dtw_core_ref_reader #(
   parameter int DATA_WIDTH       = 16,
   parameter int ADDR_WIDTH       = 32,
   parameter int REFMEM_PTR_WIDTH = 20
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        rs_in,
   input  logic                        ref_valid_in,
   input  logic [ADDR_WIDTH-1:0]       ref_len_in,
   output logic                        busy_out,
   output logic                        done_out,
   output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out,
   input  logic [DATA_WIDTH-1:0]       ref_data_in,
   output logic                        out_valid_out,
   input  logic                        out_ready_in,
   output logic [DATA_WIDTH-1:0]       out_data_out,
   output logic                        out_last_out,
   output logic [1:0]                  dbg_state
);

   // Counters are one bit wider than the memory pointer so a full-memory
   // reference (2^REFMEM_PTR_WIDTH samples) can be counted without wrapping.
   localparam int CW = REFMEM_PTR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] MAX_LEN = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << REFMEM_PTR_WIDTH;
   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [2:0] BUF_DEPTH = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state, state_next;

   logic                  rs_prev;
   logic [CW-1:0]         len;
   logic [CW-1:0]         issued;
   logic [CW-1:0]         sent;
   logic                  inflight;
   logic                  done_q;

   logic [DATA_WIDTH-1:0] fifo_q [4];
   logic [1:0]            wr_ptr;
   logic [1:0]            rd_ptr;
   logic [2:0]            count;

   logic                  start_req;
   logic [CW-1:0]         len_capped;
   logic [CW-1:0]         len_m1;
   logic                  busy;
   logic                  abort;
   logic [2:0]            credit_used;
   logic                  can_issue;
   logic                  push;
   logic                  pop;
   logic                  last_hs;

   // Decode start, abort, issue credit and handshake conditions for this cycle.
   always_comb begin
      start_req   = (state == IDLE) && rs_in && !rs_prev && ref_valid_in;
      len_capped  = (ref_len_in > MAX_LEN) ? MAX_LEN[CW-1:0] : ref_len_in[CW-1:0];
      len_m1      = len - ONE;
      busy        = (state == FETCH) || (state == DRAIN);
      abort       = busy && !rs_in;
      credit_used = count + {2'b00, inflight};
      can_issue   = (state == FETCH) && rs_in && (issued < len) && (credit_used < BUF_DEPTH);
      push        = inflight && !abort;
      pop         = (count != 3'd0) && out_ready_in;
      last_hs     = (state == DRAIN) && pop && (sent == len_m1);
   end

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: a zero-length start never leaves IDLE, abort wins over completion.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_req && (len_capped != '0)) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            if (abort) begin
               state_next = IDLE;
            end else if (issued == len) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (abort || last_hs) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Pass bookkeeping: length latch, issue/beat counters, read address and done pulse.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rs_prev      <= 1'b0;
         len          <= '0;
         issued       <= '0;
         sent         <= '0;
         inflight     <= 1'b0;
         ref_addr_out <= '0;
         done_q       <= 1'b0;
      end else begin
         rs_prev  <= rs_in;
         inflight <= can_issue;
         done_q   <= (start_req && (len_capped == '0)) || (last_hs && !abort);
         if (start_req) begin
            len    <= len_capped;
            issued <= '0;
            sent   <= '0;
         end else begin
            if (can_issue) begin
               ref_addr_out <= issued[REFMEM_PTR_WIDTH-1:0];
               issued       <= issued + ONE;
            end
            if (pop) begin
               sent <= sent + ONE;
            end
         end
      end
   end

   // Skid buffer pointers and occupancy; abort flushes everything including the in-flight read.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else if (abort) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // Skid buffer storage captures the read data one cycle after each issue.
   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_q[wr_ptr] <= ref_data_in;
      end
   end

   assign busy_out      = busy;
   assign done_out      = done_q;
   assign out_valid_out = (count != 3'd0);
   assign out_data_out  = (count != 3'd0) ? fifo_q[rd_ptr] : '0;
   assign out_last_out  = (count != 3'd0) && (sent == len_m1);
   assign dbg_state     = state;

endmodule

// File: tb/tb_dtw_core_ref_reader.sv
// Self-checking bench for dtw_core_ref_reader: table-driven passes, directed
// corner cases (start gating, abort, async reset) and random passes compared
// against a memory-content reference model.

module tb_dtw_core_ref_reader;

   localparam int DW = 16;
   localparam int AW = 32;
   localparam int PW = 20;

   logic          clk_in = 1'b0;
   logic          rst_n_in;
   logic          rs_in;
   logic          ref_valid_in;
   logic [AW-1:0] ref_len_in;
   logic          busy_out;
   logic          done_out;
   logic [PW-1:0] ref_addr_out;
   logic [DW-1:0] ref_data_in;
   logic          out_valid_out;
   logic          out_ready_in;
   logic [DW-1:0] out_data_out;
   logic          out_last_out;
   logic [1:0]    dbg_state;

   dtw_core_ref_reader #(
      .DATA_WIDTH      (DW),
      .ADDR_WIDTH      (AW),
      .REFMEM_PTR_WIDTH(PW)
   ) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .rs_in        (rs_in),
      .ref_valid_in (ref_valid_in),
      .ref_len_in   (ref_len_in),
      .busy_out     (busy_out),
      .done_out     (done_out),
      .ref_addr_out (ref_addr_out),
      .ref_data_in  (ref_data_in),
      .out_valid_out(out_valid_out),
      .out_ready_in (out_ready_in),
      .out_data_out (out_data_out),
      .out_last_out (out_last_out),
      .dbg_state    (dbg_state)
   );

   always #5 clk_in = ~clk_in;

   // Reference memory: registered address (ref_addr_out), data valid the following cycle.
   logic [DW-1:0] mem [256];
   assign ref_data_in = mem[ref_addr_out[7:0]];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int   got_data[$];
   int   got_last[$];
   int   pass_done;
   int   first_valid_cyc;
   int   first_hs_cyc;
   int   last_hs_cyc;
   int   done_cyc;
   int   start_cyc = 0;
   bit   saw_valid;
   bit   saw_busy;
   bit   busy_at_done;
   bit   prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic prev_last;

   typedef struct {
      int len;
      int ready_mode;
      int exp_beats;
      int exp_done;
      bit timing;
   } vec_t;

   vec_t vecs[6];

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check_output(input string name, input longint actual, input longint expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: collects handshakes, done pulses and checks stall stability / issue lead.
   always @(negedge clk_in) begin
      if (!rst_n_in) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_output("stall_valid", out_valid_out, 1);
            check_output("stall_data", out_data_out, prev_data);
            check_output("stall_last", out_last_out, prev_last);
         end
         if (out_valid_out) begin
            saw_valid = 1'b1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (busy_out) begin
            saw_busy = 1'b1;
            if (cyc >= start_cyc + 2) begin
               check_output("addr_lead", (int'(ref_addr_out) < got_data.size() + 4) ? 1 : 0, 1);
            end
         end
         if (done_out) begin
            pass_done++;
            done_cyc     = cyc;
            busy_at_done = busy_out;
         end
         if (out_valid_out && out_ready_in) begin
            got_data.push_back(int'(out_data_out));
            got_last.push_back(int'(out_last_out));
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
         end
         prev_stall = out_valid_out && !out_ready_in;
         prev_data  = out_data_out;
         prev_last  = out_last_out;
      end
   end

   function automatic logic ready_for(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return (k % 3 == 0);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic clear_monitor();
      got_data.delete();
      got_last.delete();
      pass_done       = 0;
      first_valid_cyc = -1;
      first_hs_cyc    = -1;
      last_hs_cyc     = -1;
      done_cyc        = -1;
      saw_valid       = 1'b0;
      saw_busy        = 1'b0;
      busy_at_done    = 1'b0;
   endtask

   task automatic fill_mem_linear();
      for (int i = 0; i < 256; i++) mem[i] = 16'(i + 100);
   endtask

   // Lowers rs_in for a cycle and raises it; the following edge is the start edge.
   task automatic start_pass(input int len);
      clear_monitor();
      ref_len_in = AW'(len);
      rs_in = 1'b0;
      @(posedge clk_in); #1;
      rs_in     = 1'b1;
      start_cyc = cyc;
   endtask

   // Runs one pass with the given ready pattern, bounded by a cycle budget.
   task automatic apply_stimulus(input int len, input int ready_mode);
      start_pass(len);
      for (int k = 0; k < 200; k++) begin
         out_ready_in = ready_for(ready_mode, k);
         @(posedge clk_in); #1;
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      end
      rs_in        = 1'b0;
      out_ready_in = 1'b1;
   endtask

   // Compares the captured pass against the model: beats are mem[0..len-1] in order.
   task automatic check_pass(input string tag, input int len, input int exp_done, input bit timing);
      int exp_q[$];
      for (int i = 0; i < len; i++) exp_q.push_back(int'(mem[i]));
      check_output({tag, " beats"}, got_data.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
         check_output($sformatf("%s data[%0d]", tag, i), got_data[i], exp_q[i]);
         check_output($sformatf("%s last[%0d]", tag, i), got_last[i], (i == exp_q.size() - 1) ? 1 : 0);
      end
      check_output({tag, " done"}, pass_done, exp_done);
      if (len == 0) begin
         check_output({tag, " valid_seen"}, saw_valid, 0);
         check_output({tag, " busy_seen"}, saw_busy, 0);
      end
      if (timing && len > 0) begin
         check_output({tag, " first_latency"}, first_valid_cyc - start_cyc, 3);
         check_output({tag, " burst_span"}, last_hs_cyc - first_hs_cyc, len - 1);
         check_output({tag, " done_delay"}, done_cyc - last_hs_cyc, 1);
         check_output({tag, " busy_at_done"}, busy_at_done, 0);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_output({tag, " busy"}, busy_out, 0);
      check_output({tag, " done"}, done_out, 0);
      check_output({tag, " addr"}, ref_addr_out, 0);
      check_output({tag, " valid"}, out_valid_out, 0);
      check_output({tag, " data"}, out_data_out, 0);
      check_output({tag, " last"}, out_last_out, 0);
      check_output({tag, " state"}, dbg_state, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 500000");
      $fatal(1);
   end

   initial begin
      int addr_before;
      int len;

      vecs[0] = '{8, 0, 8, 1, 1'b1};
      vecs[1] = '{8, 1, 8, 1, 1'b0};
      vecs[2] = '{0, 0, 0, 1, 1'b0};
      vecs[3] = '{1, 0, 1, 1, 1'b1};
      vecs[4] = '{5, 2, 5, 1, 1'b0};
      vecs[5] = '{4, 1, 4, 1, 1'b0};

      rst_n_in     = 1'b0;
      rs_in        = 1'b0;
      ref_valid_in = 1'b1;
      ref_len_in   = '0;
      out_ready_in = 1'b1;
      fill_mem_linear();
      clear_monitor();
      #12;
      check_idle_outputs("reset");
      #5;
      rst_n_in = 1'b1;
      @(posedge clk_in); #1;

      $display("[TB] table-driven passes");
      for (int v = 0; v < 6; v++) begin
         fill_mem_linear();
         apply_stimulus(vecs[v].len, vecs[v].ready_mode);
         check_output($sformatf("vec%0d beat_count", v), got_data.size(), vecs[v].exp_beats);
         check_pass($sformatf("vec%0d", v), vecs[v].len, vecs[v].exp_done, vecs[v].timing);
      end

      $display("[TB] start gating by ref_valid_in and rs_in edge");
      fill_mem_linear();
      rs_in = 1'b0;
      @(posedge clk_in); #1;
      clear_monitor();
      addr_before  = int'(ref_addr_out);
      ref_valid_in = 1'b0;
      ref_len_in   = 32'd4;
      rs_in        = 1'b1;
      repeat (5) @(posedge clk_in);
      #1;
      check_output("novalid state", dbg_state, 0);
      check_output("novalid addr", ref_addr_out, addr_before);
      ref_valid_in = 1'b1;
      repeat (5) @(posedge clk_in);
      #1;
      check_output("noedge state", dbg_state, 0);
      check_output("noedge busy_seen", saw_busy, 0);
      check_output("noedge done", pass_done, 0);
      apply_stimulus(3, 0);
      check_pass("edge_after_valid", 3, 1, 1'b1);

      $display("[TB] abort after 5 beats");
      fill_mem_linear();
      start_pass(16);
      out_ready_in = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk_in); #1;
         if (got_data.size() >= 5) break;
      end
      rs_in = 1'b0;
      @(posedge clk_in); #1;
      check_output("abort valid", out_valid_out, 0);
      check_output("abort state", dbg_state, 0);
      check_output("abort busy", busy_out, 0);
      repeat (4) @(posedge clk_in);
      #1;
      check_output("abort done", pass_done, 0);
      check_output("abort beats_ok", (got_data.size() >= 5 && got_data.size() <= 6) ? 1 : 0, 1);
      for (int i = 0; i < got_data.size(); i++) begin
         check_output($sformatf("abort data[%0d]", i), got_data[i], int'(mem[i]));
      end
      apply_stimulus(16, 0);
      check_pass("restart", 16, 1, 1'b1);

      $display("[TB] asynchronous reset mid-pass");
      fill_mem_linear();
      start_pass(16);
      out_ready_in = 1'b0;
      repeat (6) @(posedge clk_in);
      #3;
      rst_n_in = 1'b0;
      rs_in    = 1'b0;
      #1;
      check_idle_outputs("midreset");
      repeat (2) @(posedge clk_in);
      #3;
      rst_n_in     = 1'b1;
      out_ready_in = 1'b1;
      repeat (4) @(posedge clk_in);
      #1;
      check_output("postreset beats", got_data.size(), 0);
      check_output("postreset done", pass_done, 0);
      apply_stimulus(4, 0);
      check_pass("after_reset", 4, 1, 1'b1);

      $display("[TB] random passes against the memory model");
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
         len = $urandom_range(0, 12);
         apply_stimulus(len, 2);
         check_pass($sformatf("rand%0d", r), len, 1, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dtw_core_ref_reader.md
# dtw_core_ref_reader

Streams a stored reference sequence out of the DTW core reference memory as a valid/ready sample stream. It is the read-side counterpart of the reference load path. It drives the reference-memory address and consumes the one-cycle-latency read data. Its output feeds the DTW datapath, or the host readback FIFO for reference verification. A 4-entry skid buffer absorbs the memory read latency so the stream sustains one sample per cycle under continuous `out_ready_in`.

## Interface
- `DATA_WIDTH`, 16, sample width; must equal the reference memory width.
- `ADDR_WIDTH`, 32, width of `ref_len_in`.
- `REFMEM_PTR_WIDTH`, 20, reference memory address width.
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `rs_in`  in  1  run/stop. A rising level in IDLE starts a pass. Low in any other state aborts the pass.
- `ref_valid_in`  in  1  reference memory holds a complete reference (load-done flag); start is ignored while 0.
- `ref_len_in`  in  ADDR_WIDTH  number of samples to stream; sampled at start.
- `busy_out`  out  1  high in FETCH and DRAIN.
- `done_out`  out  1  one-cycle pulse after the last beat handshakes.
- `ref_addr_out`  out  REFMEM_PTR_WIDTH  registered read address to the reference memory.
- `ref_data_in`  in  DATA_WIDTH  memory read data, valid the cycle after the address is presented.
- `out_valid_out`  out  1  stream valid.
- `out_ready_in`  in  1  stream ready.
- `out_data_out`  out  DATA_WIDTH  stream sample.
- `out_last_out`  out  1  high with the final sample of the pass.
- `dbg_state`  out  2  current FSM state.

## Operation
- States: IDLE=0, FETCH=1, DRAIN=2.
- IDLE → FETCH when `rs_in`=1, `ref_valid_in`=1, and `rs_in` was 0 in the previous cycle (edge-qualified, so one pass per run request).
  - On this transition, latch `len` = min(`ref_len_in`, 2^REFMEM_PTR_WIDTH).
  - Clear the issue counter `issued` (width REFMEM_PTR_WIDTH+1) and the beat counter `sent`.
- `len`=0 at start: no FETCH. Pulse `done_out` the next cycle, stay IDLE, and emit no beats.
- FETCH issue condition: a read issues in a cycle when `issued` < `len` and buffer occupancy + in-flight reads < 4.
  - Occupancy does not include a same-cycle pop.
  - Issue: `ref_addr_out` <= `issued`[PTR-1:0]; `issued` += 1; set the in-flight flag for the next cycle.
- The in-flight read's `ref_data_in` is pushed into the 4-entry buffer the cycle after issue. The buffer never overflows, by the credit rule above.
- FETCH → DRAIN when `issued` reaches `len`.
- DRAIN → IDLE when the beat with `sent` = `len`-1 handshakes (`out_valid_out` & `out_ready_in`). `done_out` pulses in that transition cycle + 1.
- Stream output:
  - `out_valid_out` = buffer non-empty.
  - `out_data_out` = head entry.
  - `out_last_out` = head is sample index `len`-1.
  - Pop on handshake; `sent` += 1.
- Abort: `rs_in`=0 in FETCH or DRAIN.
  - Next cycle: state IDLE, buffer flushed, any in-flight read discarded, `out_valid_out`=0.
  - `done_out` not pulsed.
- `out_data_out` and `out_last_out` hold stable while `out_valid_out`=1 and `out_ready_in`=0.
- Simultaneous push and pop on a full buffer cannot occur by the credit rule. Push and pop in the same cycle at any other occupancy leaves occupancy unchanged.

## Timing
- Reset values: `busy_out`=0, `done_out`=0, `ref_addr_out`=0, `out_valid_out`=0, `out_data_out`=0, `out_last_out`=0, `dbg_state`=0. Buffer is empty and counters are 0.
- Reset mid-pass returns all outputs to their reset values immediately; no beat or done pulse follows.
- Start latency, counting the edge that samples the start condition as edge 0:
  - `ref_addr_out`=0 after edge 1.
  - Data pushed at edge 2.
  - `out_valid_out`=1 after edge 2, i.e., 2 cycles from start.
- Throughput: 1 beat/cycle with `out_ready_in` held high, with no bubbles after the first beat.
- Backpressure: with `out_ready_in` low, at most 4 reads are outstanding plus buffered. Issue resumes the cycle after a pop frees a credit.
- `busy_out` rises 1 cycle after the start edge and falls in the same cycle `done_out` pulses.
- Address wrap: none. `len` is capped at 2^REFMEM_PTR_WIDTH, and `issued` saturates at `len`.

## Test plan
- Preload memory[i]=i+100, `ref_len_in`=8, `out_ready_in`=1, `rs_in` rising → beats 100..107 on 8 consecutive cycles. First beat is 2 cycles after the start edge. `out_last_out` is high only on 107. `done_out` is a single pulse one cycle later.
- Same setup with `out_ready_in` toggled 1,0,0,1,… → same 8 values in order. Data is stable while stalled. `ref_addr_out` never leads `sent` by more than 4.
- `ref_len_in`=0 → `done_out` pulses once, `out_valid_out` stays 0, `busy_out` stays 0.
- `ref_valid_in`=0 with `rs_in` rising → FSM stays IDLE and no address changes. Holding `rs_in` high then raising `ref_valid_in` → no start without a new `rs_in` edge.
- `ref_len_in`=16; drop `rs_in` after 5 beats → `out_valid_out` is 0 the next cycle, no `done_out`. A new `rs_in` edge restarts from sample 0.
- Assert `rst_n_in` low mid-pass, asynchronously between edges → all outputs are 0 immediately. After release, a normal `ref_len_in`=4 pass succeeds.
